// File: rtl/arb_sel_pkg.sv
// rtl/arb_sel_pkg.sv - select codes and state type shared by the arbiter and the downstream decoder
package arb_sel_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam logic [2:0] SEL_R0   = 3'b000;
    localparam logic [2:0] SEL_R1   = 3'b001;
    localparam logic [2:0] SEL_R2   = 3'b010;
    localparam logic [2:0] SEL_R3   = 3'b100;
    localparam logic [2:0] SEL_IDLE = 3'b111;

    function automatic logic [2:0] id2sel(input logic [1:0] id);
        logic [2:0] code;
        unique case (id)
            2'd0: code = SEL_R0;
            2'd1: code = SEL_R1;
            2'd2: code = SEL_R2;
            2'd3: code = SEL_R3;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational four-way round-robin picker starting after the last owner
module rr_pick4
    import arb_sel_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       any,
    output logic [1:0] win
);

    logic [1:0] idx;

    // The last owner is visited last, so it only wins when nobody else asks.
    always_comb begin
        any = 1'b0;
        win = 2'd0;
        idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/rr_sel_arbiter.sv
// rtl/rr_sel_arbiter.sv - round-robin arbiter with bounded tenure driving a registered select code
module rr_sel_arbiter
    import arb_sel_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       clr,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic [1:0] gnt_id,
    output logic       rotated
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [3:0]       owner_mask;
    logic [3:0]       pick_req;
    logic             any;
    logic [1:0]       win;
    logic             load;
    logic             release_gnt;
    logic             rot_nxt;

    // While granted, the owner is masked so "any" means "someone else is waiting".
    assign owner_mask = 4'b0001 << gnt_id;
    assign pick_req   = (state == GRANT) ? (req & ~owner_mask) : req;

    rr_pick4 u_pick (
        .req  (pick_req),
        .last (last),
        .any  (any),
        .win  (win)
    );

    always_comb begin
        load        = 1'b0;
        release_gnt = 1'b0;
        rot_nxt     = 1'b0;
        unique case (state)
            IDLE: load = any;
            GRANT: begin
                if (|(req & owner_mask)) begin
                    if (cnt == CNT_W'(HOLD_CYCLES) && any) begin
                        load    = 1'b1;
                        rot_nxt = 1'b1;
                    end
                end else if (any) begin
                    load = 1'b1;
                end else begin
                    release_gnt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 2'd3;
            sel       <= SEL_IDLE;
            sel_valid <= 1'b0;
            gnt_id    <= 2'd0;
            rotated   <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            sel       <= SEL_IDLE;
            sel_valid <= 1'b0;
            gnt_id    <= 2'd0;
            rotated   <= 1'b0;
        end else begin
            rotated <= rot_nxt;
            if (load) begin
                state     <= GRANT;
                cnt       <= CNT_W'(1);
                last      <= win;
                gnt_id    <= win;
                sel       <= id2sel(win);
                sel_valid <= 1'b1;
            end else if (release_gnt) begin
                state     <= IDLE;
                cnt       <= '0;
                gnt_id    <= 2'd0;
                sel       <= SEL_IDLE;
                sel_valid <= 1'b0;
            end else if (state == GRANT && cnt < CNT_W'(HOLD_CYCLES)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb/tb_rr_sel_arbiter.sv - directed self-checking bench for rr_sel_arbiter with decoder check
module tb_rr_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       clr;
    logic [2:0] sel;
    logic       sel_valid;
    logic [1:0] gnt_id;
    logic       rotated;

    int vectors;
    int miscompares;
    bit mon_en;

    rr_sel_arbiter #(.HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .clr       (clr),
        .sel       (sel),
        .sel_valid (sel_valid),
        .gnt_id    (gnt_id),
        .rotated   (rotated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_sel(input logic [1:0] id);
        case (id)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [3:0] decode(input logic [2:0] code);
        case (code)
            3'b000:  return 4'b0001;
            3'b001:  return 4'b0010;
            3'b010:  return 4'b0100;
            3'b100:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Downstream decoder view: only legal codes, one-hot or zero, consistent with sel_valid.
    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (!(sel inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b111}) ||
                ($countones(decode(sel)) > 1) ||
                (sel_valid !== (decode(sel) != 4'b0000))) begin
                $display("FAIL decoder sel=%b dec=%b sel_valid=%b", sel, decode(sel), sel_valid);
                miscompares++;
            end
        end
    end

    task automatic test_reset();
        apply_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if (sel !== 3'b111 || sel_valid !== 1'b0 || gnt_id !== 2'd0 || rotated !== 1'b0) begin
                $display("FAIL reset_idle cyc%0d got sel=%b v=%b id=%0d rot=%b want 111/0/0/0",
                         i, sel, sel_valid, gnt_id, rotated);
                miscompares++;
            end
        end
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            cyc();
            vectors++;
            if (sel !== 3'b010 || sel_valid !== 1'b1 || gnt_id !== 2'd2 || rotated !== 1'b0) begin
                $display("FAIL single cyc%0d got sel=%b v=%b id=%0d rot=%b want 010/1/2/0",
                         i, sel, sel_valid, gnt_id, rotated);
                miscompares++;
            end
        end
        req = 4'b0000;
        cyc();
        vectors++;
        if (sel !== 3'b111 || sel_valid !== 1'b0 || gnt_id !== 2'd0) begin
            $display("FAIL single_drop got sel=%b v=%b id=%0d want 111/0/0", sel, sel_valid, gnt_id);
            miscompares++;
        end
    endtask

    task automatic test_contention();
        logic [1:0] id;
        logic       er;
        apply_reset();
        req = 4'b1111;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            id = 2'(((k - 1) / 4) % 4);
            er = (k > 1) && (((k - 1) % 4) == 0);
            vectors++;
            if (gnt_id !== id || sel !== exp_sel(id) || sel_valid !== 1'b1 || rotated !== er) begin
                $display("FAIL contention cyc%0d got id=%0d sel=%b v=%b rot=%b want id=%0d sel=%b v=1 rot=%b",
                         k, gnt_id, sel, sel_valid, rotated, id, exp_sel(id), er);
                miscompares++;
            end
        end
        req = 4'b0000;
        cyc();
    endtask

    task automatic test_early_release();
        apply_reset();
        req = 4'b0010;
        cyc();
        vectors++;
        if (sel !== 3'b001 || gnt_id !== 2'd1) begin
            $display("FAIL early_first got sel=%b id=%0d want 001/1", sel, gnt_id);
            miscompares++;
        end
        req = 4'b1010;
        cyc();
        req = 4'b1000;
        cyc();
        vectors++;
        if (sel !== 3'b100 || sel_valid !== 1'b1 || gnt_id !== 2'd3 || rotated !== 1'b0) begin
            $display("FAIL early_handover got sel=%b v=%b id=%0d rot=%b want 100/1/3/0",
                     sel, sel_valid, gnt_id, rotated);
            miscompares++;
        end
        repeat (3) cyc();
        // Owner 3 is at its tenure limit and drops in the same cycle: a drop, not a rotation.
        req = 4'b0001;
        cyc();
        vectors++;
        if (sel !== 3'b000 || sel_valid !== 1'b1 || gnt_id !== 2'd0 || rotated !== 1'b0) begin
            $display("FAIL drop_at_expiry got sel=%b v=%b id=%0d rot=%b want 000/1/0/0",
                     sel, sel_valid, gnt_id, rotated);
            miscompares++;
        end
        req = 4'b0000;
        cyc();
    endtask

    task automatic test_clr_reset();
        apply_reset();
        req = 4'b0100;
        cyc();
        cyc();
        vectors++;
        if (sel !== 3'b010 || gnt_id !== 2'd2) begin
            $display("FAIL clr_setup got sel=%b id=%0d want 010/2", sel, gnt_id);
            miscompares++;
        end
        clr = 1'b1;
        cyc();
        vectors++;
        if (sel !== 3'b111 || sel_valid !== 1'b0 || gnt_id !== 2'd0 || rotated !== 1'b0) begin
            $display("FAIL clr got sel=%b v=%b id=%0d rot=%b want 111/0/0/0", sel, sel_valid, gnt_id, rotated);
            miscompares++;
        end
        clr = 1'b0;
        cyc();
        vectors++;
        if (sel !== 3'b010 || sel_valid !== 1'b1 || gnt_id !== 2'd2) begin
            $display("FAIL clr_regrant got sel=%b v=%b id=%0d want 010/1/2", sel, sel_valid, gnt_id);
            miscompares++;
        end
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (sel !== 3'b111 || sel_valid !== 1'b0 || gnt_id !== 2'd0 || rotated !== 1'b0) begin
            $display("FAIL async_reset got sel=%b v=%b id=%0d rot=%b want 111/0/0/0",
                     sel, sel_valid, gnt_id, rotated);
            miscompares++;
        end
        req = 4'b1010;
        cyc();
        rst_n = 1'b1;
        mon_en = 1'b1;
        cyc();
        vectors++;
        if (sel !== 3'b001 || sel_valid !== 1'b1 || gnt_id !== 2'd1) begin
            $display("FAIL post_reset got sel=%b v=%b id=%0d want 001/1/1", sel, sel_valid, gnt_id);
            miscompares++;
        end
        req = 4'b0000;
        cyc();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        req         = 4'b0000;
        clr         = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_early_release();
        test_clr_reset();
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
